learn_costs_param: RTL and testbench
====================================

Name: learn_costs_param

Overview:
- Parametrised successor to the Q-routing cost-learning block; runs once per received feedback packet (source ID, battery status, Q-value, cluster ID).
- Searches the neighbour table in shared data memory; updates the matching entry or appends a new one, then copies the node's known-sink list into that neighbour's sink-ID row.
- Sits between the packet parser and the shared word memory; flags re-initialisation when the advertised cost rises.
- Unlike the previous generation it is re-triggerable, bounds-checked and parametrised in widths, table depth and memory map.

Parameters:
- WORD_WIDTH, 16, data and address word width
- MAX_NB, 32, neighbour table capacity (entries)
- MAX_SINK, 8, sink slots per neighbour row
- KSINK_BASE, 16'h008, known-sink list base address
- NBID_BASE, 16'h048, neighbour ID array base address
- CLUS_BASE, 16'h0C8, neighbour cluster ID array base address
- BATT_BASE, 16'h148, neighbour battery array base address
- QVAL_BASE, 16'h1C8, neighbour Q-value array base address
- SINKID_BASE, 16'h248, sink-ID rows base address; row stride is 2*MAX_SINK bytes
- KSCNT_ADDR, 16'h688, knownSinkCount word address
- NBCNT_ADDR, 16'h68A, neighbourCount word address
- SCNT_BASE, 16'h68E, per-neighbour sinkIDCount array base address

Ports:
- clock  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- fsourceID  in  WORD_WIDTH  feedback source node ID
- fbatteryStat  in  WORD_WIDTH  feedback battery status
- fValue  in  WORD_WIDTH  feedback Q-value, unsigned
- fclusterID  in  WORD_WIDTH  feedback cluster ID
- data_in  in  WORD_WIDTH  memory read data
- address  out  WORD_WIDTH  memory byte address, registered
- wr_en  out  1  memory write strobe, registered
- data_out  out  WORD_WIDTH  memory write data, registered
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- reinit  out  1  valid with done; held until the next start
- new_entry  out  1  valid with done; 1 = neighbour appended
- table_full  out  1  valid with done; 1 = append refused

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; address, data_out = 0; wr_en, busy, done, reinit, new_entry, table_full = 0; n, k = 0. Reset mid-operation aborts immediately; no further writes.
- Memory model: combinational read. data_in is valid the cycle after address is registered. Every read is an ADDR state followed by a CAP state.
- Writes: wr_en high for exactly one cycle per write, with address/data_out stable in that cycle. wr_en is never high during a read.
- Inputs f* are latched at start; changes while busy are ignored.
- Addressing: word i of an array is at BASE+2*i. Sink-ID slot (n,k) is at SINKID_BASE+n*2*MAX_SINK+2*k. All sums truncate to WORD_WIDTH.
- Counts: knownSinkCount is clamped to MAX_SINK; neighbourCount is clamped to MAX_NB.
- States:
  - IDLE: on start, clear flags and n, k; go to RD_NCNT.
  - RD_NCNT: read NBCNT_ADDR into nc.
  - RD_KSCNT: read KSCNT_ADDR into kc.
  - SEARCH: if n==nc, go to APPEND_CHK. Otherwise read NBID[n]; on match go to UPD_BATT, else n++ and repeat.
  - UPD_BATT: write BATT[n]=fbatteryStat.
  - UPD_Q: read QVAL[n] into q_old; write QVAL[n]=fValue; reinit=(q_old<fValue); go to COPY.
  - APPEND_CHK: if nc==MAX_NB, set table_full=1 and go to FINISH (no writes). Otherwise n=nc, new_entry=1, and write NBID, BATT, QVAL, CLUS at index n (4 consecutive write cycles); go to COPY. reinit=0 on append.
  - COPY: for k=0..kc-1, read KSINK[k] then write the sink-ID slot (n,k). Then write SCNT[n]=kc. On append only, also write NBCNT_ADDR=nc+1. Go to FINISH.
  - FINISH: done=1 for one cycle, busy=0; return to IDLE.
- Boundaries:
  - kc=0: no copy cycles; SCNT[n]=0 is still written.
  - Duplicate IDs in the table: the lowest index wins.
  - start while busy: ignored.
  - start in the same cycle as done: ignored.

Optional Feature:
- Macro: LEARN_COSTS_CLUSTER_REFRESH_EN.
- Defined: the update path also writes CLUS[n]=fclusterID, as one extra write cycle after UPD_BATT.
- Undefined: the cluster ID of an existing neighbour is never rewritten; it is written only on append.

Test Plan:
- Memory nc=2, NBID={5,9}, QVAL[1]=10, kc=2, KSINK={3,4}; start with src=9, batt=77, val=20 -> BATT[1]=77, QVAL[1]=20, slots (1,0)=3, (1,1)=4, SCNT[1]=2; done with reinit=1, new_entry=0.
- Same memory, val=5 -> QVAL[1]=5, reinit=0.
- nc=2, src=12, clus=6 -> NBID[2]=12, CLUS[2]=6, SCNT[2]=kc, NBCNT=3; new_entry=1, reinit=0.
- nc=MAX_NB=32, unknown src -> no wr_en pulses at all; done with table_full=1; NBCNT stays 32.
- kc=0, existing neighbour -> zero KSINK reads, SCNT[n]=0, done asserted; a second start immediately after done completes again with correct results.
- rst pulsed mid-COPY -> outputs return to reset values next cycle; no wr_en thereafter; a fresh start completes normally.

Source files
------------

// File: rtl/learn_costs_param.sv
// Q-routing cost learner: finds/appends a neighbour entry in shared word memory and copies the known-sink list into its row.
// Optional LEARN_COSTS_CLUSTER_REFRESH_EN also rewrites the cluster ID of an existing neighbour.
module learn_costs_param #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned MAX_NB     = 32,
    parameter int unsigned MAX_SINK   = 8,
    parameter logic [WORD_WIDTH-1:0] KSINK_BASE  = 16'h008,
    parameter logic [WORD_WIDTH-1:0] NBID_BASE   = 16'h048,
    parameter logic [WORD_WIDTH-1:0] CLUS_BASE   = 16'h0C8,
    parameter logic [WORD_WIDTH-1:0] BATT_BASE   = 16'h148,
    parameter logic [WORD_WIDTH-1:0] QVAL_BASE   = 16'h1C8,
    parameter logic [WORD_WIDTH-1:0] SINKID_BASE = 16'h248,
    parameter logic [WORD_WIDTH-1:0] KSCNT_ADDR  = 16'h688,
    parameter logic [WORD_WIDTH-1:0] NBCNT_ADDR  = 16'h68A,
    parameter logic [WORD_WIDTH-1:0] SCNT_BASE   = 16'h68E
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] fsourceID,
    input  logic [WORD_WIDTH-1:0] fbatteryStat,
    input  logic [WORD_WIDTH-1:0] fValue,
    input  logic [WORD_WIDTH-1:0] fclusterID,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] address,
    output logic                  wr_en,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  reinit,
    output logic                  new_entry,
    output logic                  table_full
);
    localparam int unsigned WW  = WORD_WIDTH;
    localparam int unsigned NW  = $clog2(MAX_NB + 1);
    localparam int unsigned KW  = $clog2(MAX_SINK + 1);
    localparam int unsigned ROW = 2 * MAX_SINK;

    typedef enum logic [4:0] {
        IDLE, NCNT_A, NCNT_C, KCNT_A, KCNT_C, SRCH_A, SRCH_C,
        UPD_BATT, UPD_CLUS, UPD_QA, UPD_QC,
        APP_CHK, APP_ID, APP_BATT, APP_Q, APP_CLUS,
        COPY_A, COPY_C, SCNT_W, NCNT_W, FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   n_q, n_d, nc_q, nc_d;
    logic [KW-1:0]   k_q, k_d, kc_q, kc_d;
    logic [WW-1:0]   src_q, src_d, batt_q, batt_d, val_q, val_d, clus_q, clus_d;
    logic [WW-1:0]   address_q, address_d, data_out_q, data_out_d;
    logic            wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;
    logic            reinit_q, reinit_d, new_entry_q, new_entry_d, table_full_q, table_full_d;

    function automatic logic [WW-1:0] word_addr(input logic [WW-1:0] base, input logic [WW-1:0] idx);
        return base + (idx << 1);
    endfunction

    function automatic logic [WW-1:0] slot_addr(input logic [NW-1:0] n, input logic [KW-1:0] k);
        return SINKID_BASE + WW'(n) * WW'(ROW) + (WW'(k) << 1);
    endfunction

    // Each read: *_A registers the address, *_C consumes data_in one cycle later.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        k_d          = k_q;
        nc_d         = nc_q;
        kc_d         = kc_q;
        src_d        = src_q;
        batt_d       = batt_q;
        val_d        = val_q;
        clus_d       = clus_q;
        address_d    = address_q;
        data_out_d   = data_out_q;
        wr_en_d      = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        reinit_d     = reinit_q;
        new_entry_d  = new_entry_q;
        table_full_d = table_full_q;
        case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !done_q) begin
                    src_d        = fsourceID;
                    batt_d       = fbatteryStat;
                    val_d        = fValue;
                    clus_d       = fclusterID;
                    n_d          = '0;
                    k_d          = '0;
                    reinit_d     = 1'b0;
                    new_entry_d  = 1'b0;
                    table_full_d = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = NCNT_A;
                end
            end
            NCNT_A: begin
                address_d = NBCNT_ADDR;
                state_d   = NCNT_C;
            end
            NCNT_C: begin
                nc_d    = (data_in > WW'(MAX_NB)) ? NW'(MAX_NB) : NW'(data_in);
                state_d = KCNT_A;
            end
            KCNT_A: begin
                address_d = KSCNT_ADDR;
                state_d   = KCNT_C;
            end
            KCNT_C: begin
                kc_d    = (data_in > WW'(MAX_SINK)) ? KW'(MAX_SINK) : KW'(data_in);
                state_d = SRCH_A;
            end
            SRCH_A: begin
                if (n_q == nc_q) begin
                    state_d = APP_CHK;
                end else begin
                    address_d = word_addr(NBID_BASE, WW'(n_q));
                    state_d   = SRCH_C;
                end
            end
            SRCH_C: begin
                if (data_in == src_q) begin
                    state_d = UPD_BATT;
                end else begin
                    n_d     = n_q + NW'(1);
                    state_d = SRCH_A;
                end
            end
            UPD_BATT: begin
                address_d  = word_addr(BATT_BASE, WW'(n_q));
                data_out_d = batt_q;
                wr_en_d    = 1'b1;
`ifdef LEARN_COSTS_CLUSTER_REFRESH_EN
                state_d    = UPD_CLUS;
`else
                state_d    = UPD_QA;
`endif
            end
            UPD_CLUS: begin
                address_d  = word_addr(CLUS_BASE, WW'(n_q));
                data_out_d = clus_q;
                wr_en_d    = 1'b1;
                state_d    = UPD_QA;
            end
            UPD_QA: begin
                address_d = word_addr(QVAL_BASE, WW'(n_q));
                state_d   = UPD_QC;
            end
            UPD_QC: begin
                reinit_d   = (data_in < val_q);
                data_out_d = val_q;
                wr_en_d    = 1'b1;
                state_d    = COPY_A;
            end
            APP_CHK: begin
                if (nc_q == NW'(MAX_NB)) begin
                    table_full_d = 1'b1;
                    state_d      = FINISH;
                end else begin
                    n_d         = nc_q;
                    new_entry_d = 1'b1;
                    state_d     = APP_ID;
                end
            end
            APP_ID: begin
                address_d  = word_addr(NBID_BASE, WW'(n_q));
                data_out_d = src_q;
                wr_en_d    = 1'b1;
                state_d    = APP_BATT;
            end
            APP_BATT: begin
                address_d  = word_addr(BATT_BASE, WW'(n_q));
                data_out_d = batt_q;
                wr_en_d    = 1'b1;
                state_d    = APP_Q;
            end
            APP_Q: begin
                address_d  = word_addr(QVAL_BASE, WW'(n_q));
                data_out_d = val_q;
                wr_en_d    = 1'b1;
                state_d    = APP_CLUS;
            end
            APP_CLUS: begin
                address_d  = word_addr(CLUS_BASE, WW'(n_q));
                data_out_d = clus_q;
                wr_en_d    = 1'b1;
                state_d    = COPY_A;
            end
            COPY_A: begin
                if (k_q == kc_q) begin
                    state_d = SCNT_W;
                end else begin
                    address_d = word_addr(KSINK_BASE, WW'(k_q));
                    state_d   = COPY_C;
                end
            end
            COPY_C: begin
                address_d  = slot_addr(n_q, k_q);
                data_out_d = data_in;
                wr_en_d    = 1'b1;
                k_d        = k_q + KW'(1);
                state_d    = COPY_A;
            end
            SCNT_W: begin
                address_d  = word_addr(SCNT_BASE, WW'(n_q));
                data_out_d = WW'(kc_q);
                wr_en_d    = 1'b1;
                state_d    = new_entry_q ? NCNT_W : FINISH;
            end
            NCNT_W: begin
                address_d  = NBCNT_ADDR;
                data_out_d = WW'(nc_q) + WW'(1);
                wr_en_d    = 1'b1;
                state_d    = FINISH;
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= IDLE;
            n_q          <= '0;
            k_q          <= '0;
            nc_q         <= '0;
            kc_q         <= '0;
            src_q        <= '0;
            batt_q       <= '0;
            val_q        <= '0;
            clus_q       <= '0;
            address_q    <= '0;
            data_out_q   <= '0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            reinit_q     <= 1'b0;
            new_entry_q  <= 1'b0;
            table_full_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            k_q          <= k_d;
            nc_q         <= nc_d;
            kc_q         <= kc_d;
            src_q        <= src_d;
            batt_q       <= batt_d;
            val_q        <= val_d;
            clus_q       <= clus_d;
            address_q    <= address_d;
            data_out_q   <= data_out_d;
            wr_en_q      <= wr_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            reinit_q     <= reinit_d;
            new_entry_q  <= new_entry_d;
            table_full_q <= table_full_d;
        end
    end

    assign address    = address_q;
    assign wr_en      = wr_en_q;
    assign data_out   = data_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign reinit     = reinit_q;
    assign new_entry  = new_entry_q;
    assign table_full = table_full_q;

endmodule

// File: tb/tb_learn_costs_param.sv
// Scoreboard bench for learn_costs_param: expected memory writes are queued at start and matched on each wr_en.
module tb_learn_costs_param;
    localparam logic [15:0] KSINK = 16'h008, NBID = 16'h048, CLUS = 16'h0C8, BATT = 16'h148;
    localparam logic [15:0] QVAL = 16'h1C8, SINKID = 16'h248, KSCNT = 16'h688, NBCNT = 16'h68A, SCNT = 16'h68E;

    logic        clock = 1'b0;
    logic        rst, start;
    logic [15:0] fsourceID, fbatteryStat, fValue, fclusterID, data_in, address, data_out;
    logic        wr_en, busy, done, reinit, new_entry, table_full;

    logic        pl_en;
    logic [15:0] pl_a, pl_d;
    logic [15:0] mem     [0:1023] = '{default: '0};
    logic [15:0] ref_mem [0:1023] = '{default: '0};

    typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;
    wr_t exp_q[$];
    wr_t mon_w;

    int checks = 0;
    int errors = 0;
    int ksink_rd = 0;

    learn_costs_param dut (
        .clock(clock), .rst(rst), .start(start),
        .fsourceID(fsourceID), .fbatteryStat(fbatteryStat), .fValue(fValue), .fclusterID(fclusterID),
        .data_in(data_in), .address(address), .wr_en(wr_en), .data_out(data_out),
        .busy(busy), .done(done), .reinit(reinit), .new_entry(new_entry), .table_full(table_full)
    );

    always #5 clock = ~clock;

    assign data_in = mem[address[10:1]];

    always @(posedge clock) begin
        if (pl_en)      mem[pl_a[10:1]] <= pl_d;
        else if (wr_en) mem[address[10:1]] <= data_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the expected queue.
    always @(negedge clock) begin
        if (!wr_en && address >= KSINK && address < KSINK + 16'd16) ksink_rd++;
        if (wr_en) begin
            check("wr_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_w = exp_q.pop_front();
                check("wr_addr", address, mon_w.a);
                check("wr_data", data_out, mon_w.d);
                ref_mem[mon_w.a[10:1]] = mon_w.d;
            end
        end
    end

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem[a[10:1]];
    endfunction

    function automatic logic [15:0] wa(input logic [15:0] base, input int i);
        return base + 16'(2 * i);
    endfunction

    task automatic push(input logic [15:0] a, input logic [15:0] d);
        exp_q.push_back('{a, d});
    endtask

    task automatic pl(input logic [15:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        ref_mem[a[10:1]] = d;
        @(posedge clock); #1;
        pl_en = 1'b0;
    endtask

    task automatic model_op(input logic [15:0] src, batt, val, clus, output logic e_re, e_ne, e_tf);
        int nc, kc, n;
        bit found;
        nc = int'(ref_rd(NBCNT)); if (nc > 32) nc = 32;
        kc = int'(ref_rd(KSCNT)); if (kc > 8) kc = 8;
        found = 0; n = 0;
        for (int i = 0; i < nc; i++)
            if (!found && ref_rd(wa(NBID, i)) == src) begin found = 1; n = i; end
        e_re = 0; e_ne = 0; e_tf = 0;
        if (found) begin
            push(wa(BATT, n), batt);
`ifdef LEARN_COSTS_CLUSTER_REFRESH_EN
            push(wa(CLUS, n), clus);
`endif
            push(wa(QVAL, n), val);
            e_re = ref_rd(wa(QVAL, n)) < val;
        end else if (nc == 32) begin
            e_tf = 1;
        end else begin
            n = nc;
            push(wa(NBID, n), src);
            push(wa(BATT, n), batt);
            push(wa(QVAL, n), val);
            push(wa(CLUS, n), clus);
            e_ne = 1;
        end
        if (!e_tf) begin
            for (int k = 0; k < kc; k++) push(16'h248 + 16'(16 * n) + 16'(2 * k), ref_rd(wa(KSINK, k)));
            push(wa(SCNT, n), 16'(kc));
            if (e_ne) push(NBCNT, 16'(nc + 1));
        end
    endtask

    task automatic drive_start(input logic [15:0] src, batt, val, clus);
        fsourceID = src; fbatteryStat = batt; fValue = val; fclusterID = clus;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] src, batt, val, clus, input bit poke, input string tag);
        logic e_re, e_ne, e_tf;
        bit got;
        @(posedge clock); #1;
        model_op(src, batt, val, clus, e_re, e_ne, e_tf);
        drive_start(src, batt, val, clus);
        check({tag, "_busy"}, busy, 1);
        if (poke) drive_start(16'h7777, 16'h1, 16'h0, 16'h3);
        got = 0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clock);
            if (done) got = 1;
        end
        check({tag, "_done"}, got, 1);
        check({tag, "_reinit"}, reinit, e_re);
        check({tag, "_new_entry"}, new_entry, e_ne);
        check({tag, "_table_full"}, table_full, e_tf);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_pending_wr"}, exp_q.size(), 0);
    endtask

    initial begin
        logic e_re, e_ne, e_tf;
        bit seen;
        int snap;
        rst = 1'b1; start = 1'b0; pl_en = 1'b0; pl_a = '0; pl_d = '0;
        fsourceID = '0; fbatteryStat = '0; fValue = '0; fclusterID = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_address", address, 0);
        check("rst_data_out", data_out, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_flags", {reinit, new_entry, table_full}, 0);
        rst = 1'b0;

        pl(NBCNT, 2); pl(wa(NBID, 0), 5); pl(wa(NBID, 1), 9); pl(wa(QVAL, 1), 10);
        pl(KSCNT, 2); pl(wa(KSINK, 0), 3); pl(wa(KSINK, 1), 4);

        // Existing neighbour, cost rises; a start while busy must be ignored.
        snap = ksink_rd;
        run_op(9, 77, 20, 1, 1, "t1");
        check("t1_ksink_reads", ksink_rd - snap, 2);
        check("t1_batt", mem[wa(BATT, 1) >> 1], 77);
        check("t1_qval", mem[wa(QVAL, 1) >> 1], 20);
        check("t1_slot10", mem[16'h258 >> 1], 3);
        check("t1_slot11", mem[16'h25A >> 1], 4);
        check("t1_scnt", mem[16'h690 >> 1], 2);
        check("t1_reinit", reinit, 1);

        // Cost falls; then a start coinciding with done is dropped.
        run_op(9, 78, 5, 1, 0, "t2");
        check("t2_qval", mem[wa(QVAL, 1) >> 1], 5);
        check("t2_reinit", reinit, 0);
        fsourceID = 5; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("t2_start_on_done", busy, 0);

        // Append a new neighbour.
        run_op(12, 50, 40, 6, 0, "t3");
        check("t3_nbid", mem[16'h04C >> 1], 12);
        check("t3_clus", mem[16'h0CC >> 1], 6);
        check("t3_scnt", mem[16'h692 >> 1], 2);
        check("t3_nbcnt", mem[NBCNT >> 1], 3);
        check("t3_new_entry", new_entry, 1);

        // Full table, unknown source: no writes.
        pl(NBCNT, 32);
        run_op(1000, 1, 2, 3, 0, "t4");
        check("t4_table_full", table_full, 1);
        check("t4_nbcnt", mem[NBCNT >> 1], 32);
        pl(NBCNT, 3);

        // Empty known-sink list, then back-to-back restart.
        pl(KSCNT, 0);
        snap = ksink_rd;
        run_op(5, 11, 7, 2, 0, "t5");
        check("t5_ksink_reads", ksink_rd - snap, 0);
        check("t5_scnt", mem[SCNT >> 1], 0);
        run_op(9, 12, 30, 2, 0, "t5b");
        check("t5b_qval", mem[wa(QVAL, 1) >> 1], 30);

        // Reset in the middle of the copy loop.
        pl(KSCNT, 8);
        for (int i = 2; i < 8; i++) pl(wa(KSINK, i), 16'(20 + i));
        model_op(9, 99, 50, 1, e_re, e_ne, e_tf);
        drive_start(9, 99, 50, 1);
        seen = 0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge clock);
            if (wr_en && address >= 16'h258 && address < 16'h268) seen = 1;
        end
        check("t6_copy_seen", seen, 1);
        @(posedge clock); #1;
        rst = 1'b1;
        @(posedge clock); #1;
        exp_q.delete();
        check("t6_rst_address", address, 0);
        check("t6_rst_wr_en", wr_en, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done_flags", {done, reinit, new_entry, table_full}, 0);
        rst = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("t6_idle_after_rst", busy, 0);
        run_op(9, 100, 60, 1, 0, "t6b");
        check("t6b_scnt", mem[16'h690 >> 1], 8);
        check("t6b_slot17", mem[16'h266 >> 1], 27);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
